// File: rtl/intc_irq_src.sv
// Interrupt source latch/mask/priority controller with one-cycle irq pulse and claim/EOI handshake.
// Build option: define INTC_SYNC_EN to pass src through a 2-flop synchroniser (otherwise a single flop).
module intc_irq_src #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            irq_en_in,
  output logic            irq_out,
  input  logic [2:0]      reg_addr,
  input  logic [15:0]     reg_wdata,
  input  logic            reg_we,
  output logic [15:0]     reg_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_CLAIM   = 3'd3;
  localparam logic [2:0] ADDR_EOI     = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  state_t          state_reg, state_next;
  logic            irq_reg, irq_next;
  logic            claim_valid_reg, claim_valid_next;
  logic [3:0]      claim_id_reg, claim_id_next;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] edge_reg;
  logic [NSRC-1:0] ep_reg, ep_next;
  logic [NSRC-1:0] s_reg;
  logic [NSRC-1:0] s_prev_reg;

  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] req_vec;
  logic [3:0]      sel;
  logic            wr_pending;
  logic            wr_mask;
  logic            wr_edge;
  logic            wr_eoi;
  logic            accept;
  logic            unused_wdata;

  // Only the low NSRC write bits carry meaning; EOI ignores its data entirely.
  assign unused_wdata = ^reg_wdata;

  // ---------------------------------------------------------------------------
  // Source sampling
  // ---------------------------------------------------------------------------
`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] meta_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= '0;
      s_reg    <= '0;
    end else begin
      meta_reg <= src;
      s_reg    <= meta_reg;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= '0;
    end else begin
      s_reg <= src;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_reg <= '0;
    end else begin
      s_prev_reg <= s_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Register-port decode
  // ---------------------------------------------------------------------------
  assign wr_pending = reg_we && (reg_addr == ADDR_PENDING);
  assign wr_mask    = reg_we && (reg_addr == ADDR_MASK);
  assign wr_edge    = reg_we && (reg_addr == ADDR_EDGE);
  assign wr_eoi     = reg_we && (reg_addr == ADDR_EOI);
  assign accept     = (state_reg == REQ) && irq_en_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg <= '0;
      edge_reg <= '0;
    end else begin
      if (wr_mask) mask_reg <= reg_wdata[NSRC-1:0];
      if (wr_edge) edge_reg <= reg_wdata[NSRC-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Edge-pending latches: a fresh rising edge beats any same-cycle clear
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_edge_pending
      logic rise;
      logic clr;

      assign rise = s_reg[gi] & ~s_prev_reg[gi];
      assign clr  = (wr_pending && reg_wdata[gi]) ||
                    (accept && (claim_id_reg == 4'(gi)));
      assign ep_next[gi] = rise | (ep_reg[gi] & ~clr);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ep_reg <= '0;
    end else begin
      ep_reg <= ep_next;
    end
  end

  // Level sources report their live sampled value; edge sources their latch.
  assign pending = (edge_reg & ep_reg) | (~edge_reg & s_reg);
  assign req_vec = pending & mask_reg;

  // Lowest index wins, so scan from the top and let lower hits overwrite.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_vec[i]) sel = 4'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Request / service FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      irq_reg         <= 1'b0;
      claim_valid_reg <= 1'b0;
      claim_id_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      irq_reg         <= irq_next;
      claim_valid_reg <= claim_valid_next;
      claim_id_reg    <= claim_id_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    irq_next         = 1'b0;
    claim_valid_next = claim_valid_reg;
    claim_id_next    = claim_id_reg;
    case (state_reg)
      IDLE: begin
        if ((|req_vec) && irq_en_in) begin
          claim_valid_next = 1'b1;
          claim_id_next    = sel;
          irq_next         = 1'b1;
          state_next       = REQ;
        end
      end
      REQ: begin
        // The core either takes the pulse now or the request is withdrawn.
        if (irq_en_in) begin
          state_next = SERVICE;
        end else begin
          claim_valid_next = 1'b0;
          state_next       = IDLE;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          claim_valid_next = 1'b0;
          state_next       = IDLE;
        end
      end
      default: begin
        claim_valid_next = 1'b0;
        state_next       = IDLE;
      end
    endcase
  end

  assign irq_out = irq_reg;
  assign busy    = (state_reg == REQ) || (state_reg == SERVICE);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_PENDING: reg_rdata[NSRC-1:0] = pending;
      ADDR_MASK:    reg_rdata[NSRC-1:0] = mask_reg;
      ADDR_EDGE:    reg_rdata[NSRC-1:0] = edge_reg;
      ADDR_CLAIM:   reg_rdata = {claim_valid_reg, 11'd0, claim_id_reg};
      ADDR_STATUS:  reg_rdata[1:0] = state_reg;
      default:      reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intc_irq_src.sv
// Directed + randomized bench for intc_irq_src against a rule-level reference model.
module tb_intc_irq_src;

  localparam int N = 8;
`ifdef INTC_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src = '0;
  logic          irq_en_in = 1'b0;
  logic          irq_out;
  logic [2:0]    reg_addr = '0;
  logic [15:0]   reg_wdata = '0;
  logic          reg_we = 1'b0;
  logic [15:0]   reg_rdata;
  logic          busy;

  int total = 0;
  int bad = 0;

  intc_irq_src #(.NSRC(N)) dut (
    .clk(clk), .rst(rst), .src(src), .irq_en_in(irq_en_in), .irq_out(irq_out),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: sampled-source delay line plus the controller's visible state.
  logic [N-1:0] pipe_m [D];
  logic [N-1:0] sp_m, ep_m, mask_m, edge_m;
  int           mode_m;   // 0 idle, 1 request pulse, 2 in service
  bit           cv_m;
  int           cid_m;
  bit           irq_m;

  function automatic logic [N-1:0] s_now();
    return pipe_m[D-1];
  endfunction

  function automatic logic [N-1:0] pend_now();
    return (edge_m & ep_m) | (~edge_m & s_now());
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] r;
    r = '0;
    case (a)
      3'd0: r[N-1:0] = pend_now();
      3'd1: r[N-1:0] = mask_m;
      3'd2: r[N-1:0] = edge_m;
      3'd3: r = {cv_m, 11'd0, 4'(cid_m)};
      3'd5: r[1:0] = 2'(mode_m);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < D; k++) pipe_m[k] = '0;
    sp_m = '0; ep_m = '0; mask_m = '0; edge_m = '0;
    mode_m = 0; cv_m = 0; cid_m = 0; irq_m = 0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".irq"}, {15'd0, irq_out}, {15'd0, irq_m});
    check({tag, ".busy"}, {15'd0, busy}, {15'd0, 1'(mode_m != 0)});
    check({tag, ".rdata"}, reg_rdata, model_read(reg_addr));
  endtask

  // One clock: derive next model state from current inputs, clock, then compare.
  task automatic step(input string tag);
    logic [N-1:0] req, clr, n_ep, n_mask, n_edge;
    int sel, n_mode, n_cid;
    bit n_cv, n_irq;
    if (rst !== 1'b0) begin
      @(posedge clk); #1;
      check_all(tag);
      return;
    end
    req = pend_now() & mask_m;
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (req[i]) sel = i;
    n_mode = mode_m; n_cv = cv_m; n_cid = cid_m; n_irq = 0;
    case (mode_m)
      0: if (sel >= 0 && irq_en_in) begin n_cv = 1; n_cid = sel; n_irq = 1; n_mode = 1; end
      1: if (irq_en_in) n_mode = 2; else begin n_cv = 0; n_mode = 0; end
      default: if (reg_we && reg_addr == 3'd4) begin n_cv = 0; n_mode = 0; end
    endcase
    clr = '0;
    if (reg_we && reg_addr == 3'd0) clr = reg_wdata[N-1:0];
    if (mode_m == 1 && irq_en_in) clr[cid_m] = 1'b1;
    n_ep = (ep_m & ~clr) | (s_now() & ~sp_m);
    n_mask = (reg_we && reg_addr == 3'd1) ? reg_wdata[N-1:0] : mask_m;
    n_edge = (reg_we && reg_addr == 3'd2) ? reg_wdata[N-1:0] : edge_m;
    @(posedge clk);
    sp_m = s_now();
    for (int k = D - 1; k > 0; k--) pipe_m[k] = pipe_m[k-1];
    pipe_m[0] = src;
    ep_m = n_ep; mask_m = n_mask; edge_m = n_edge;
    mode_m = n_mode; cv_m = n_cv; cid_m = n_cid; irq_m = n_irq;
    #1;
    check_all(tag);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d, input string tag);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    step(tag);
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq_out !== 1'b1 && n < 30) begin step(tag); n++; end
    check({tag, ".seen"}, {15'd0, irq_out}, 16'd1);
  endtask

  task automatic peek(input logic [2:0] a, input string tag, input logic [15:0] exp);
    reg_addr = a; #1;
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    int n;
    int pulses;
    model_reset();
    #1; check_all("reset");
    step("reset"); step("reset");
    rst = 1'b0;
    step("rel");

    // Edge source latency and accept
    write_reg(3'd1, 16'h0008, "t1.mask");
    write_reg(3'd2, 16'h0008, "t1.edge");
    irq_en_in = 1'b1; reg_addr = 3'd3;
    src[3] = 1'b1;
    n = 0;
    while (irq_out !== 1'b1 && n < 20) begin step("t1.wait"); n++; end
    check("t1.latency", 16'(n), 16'(D + 2));
    check("t1.claim", reg_rdata, 16'h8003);
    reg_addr = 3'd0;
    step("t1.accept");
    check("t1.pend3", {15'd0, reg_rdata[3]}, 16'd0);
    check("t1.busy", {15'd0, busy}, 16'd1);
    src = '0;
    write_reg(3'd4, 16'h1234, "t1.eoi");

    // Two simultaneous edges: priority then second after EOI
    write_reg(3'd2, 16'h00FF, "t2.edge");
    write_reg(3'd0, 16'h00FF, "t2.w1c");
    write_reg(3'd1, 16'h00FF, "t2.mask");
    reg_addr = 3'd3;
    src[5] = 1'b1; src[2] = 1'b1;
    wait_irq("t2.a");
    check("t2.claim_a", reg_rdata, 16'h8002);
    step("t2.acc_a");
    write_reg(3'd4, 16'h0000, "t2.eoi_a");
    reg_addr = 3'd3;
    wait_irq("t2.b");
    check("t2.claim_b", reg_rdata, 16'h8005);
    step("t2.acc_b");
    write_reg(3'd4, 16'h0000, "t2.eoi_b");
    src = '0;

    // Interrupts disabled: hold off, then pulse immediately on enable
    irq_en_in = 1'b0;
    write_reg(3'd1, 16'h0002, "t3.mask");
    reg_addr = 3'd3;
    src[1] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step("t3.hold"); if (irq_out) pulses++; end
    check("t3.nopulse", 16'(pulses), 16'd0);
    irq_en_in = 1'b1;
    step("t3.en");
    check("t3.irq", {15'd0, irq_out}, 16'd1);
    check("t3.claim", reg_rdata, 16'h8001);
    step("t3.acc");
    write_reg(3'd4, 16'h0000, "t3.eoi");
    src = '0;

    // Level source re-request, then clean drop before EOI
    write_reg(3'd2, 16'h0000, "t4.edge");
    write_reg(3'd1, 16'h0001, "t4.mask");
    src[0] = 1'b1;
    wait_irq("t4.a");
    step("t4.acc_a");
    write_reg(3'd4, 16'h0000, "t4.eoi_a");
    step("t4.rereq");
    check("t4.rereq_irq", {15'd0, irq_out}, 16'd1);
    step("t4.acc_b");
    src[0] = 1'b0;
    for (int i = 0; i < D + 1; i++) step("t4.drop");
    write_reg(3'd4, 16'h0000, "t4.eoi_b");
    pulses = 0;
    for (int i = 0; i < 4; i++) begin step("t4.quiet"); if (irq_out) pulses++; end
    check("t4.nopulse", 16'(pulses), 16'd0);
    peek(3'd5, "t4.status", 16'd0);

    // Enable drops during request pulse
    write_reg(3'd2, 16'h0040, "t5.edge");
    write_reg(3'd1, 16'h0040, "t5.mask");
    src[6] = 1'b1;
    wait_irq("t5.a");
    irq_en_in = 1'b0;
    step("t5.drop");
    peek(3'd5, "t5.status", 16'd0);
    peek(3'd3, "t5.claim", 16'h0006);
    peek(3'd0, "t5.pend", 16'h0040);
    irq_en_in = 1'b1;
    reg_addr = 3'd3;
    wait_irq("t5.b");
    check("t5.claim_b", reg_rdata, 16'h8006);
    step("t5.acc");
    src = '0;

    // Asynchronous reset during service, EOI under reset, W1C vs new edge
    write_reg(3'd4, 16'h0000, "t6.eoi0");
    write_reg(3'd2, 16'h0080, "t6.edge");
    write_reg(3'd1, 16'h0080, "t6.mask");
    src[7] = 1'b1;
    wait_irq("t6.a");
    step("t6.acc");
    check("t6.busy", {15'd0, busy}, 16'd1);
    #2 rst = 1'b1;
    #1 model_reset();
    check("t6.rst_irq", {15'd0, irq_out}, 16'd0);
    check("t6.rst_busy", {15'd0, busy}, 16'd0);
    peek(3'd1, "t6.rst_mask", 16'd0);
    peek(3'd3, "t6.rst_claim", 16'd0);
    peek(3'd5, "t6.rst_status", 16'd0);
    write_reg(3'd4, 16'h0000, "t6.eoi_rst");
    peek(3'd5, "t6.rst_status2", 16'd0);
    rst = 1'b0;
    src = '0;
    write_reg(3'd2, 16'h0010, "t6.edge4");
    src[4] = 1'b1;
    for (int i = 0; i < D; i++) step("t6.sync");
    write_reg(3'd0, 16'h0010, "t6.w1c");
    peek(3'd0, "t6.setwins", 16'h0010);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) src = N'($urandom);
      irq_en_in = ($urandom_range(4) != 0);
      reg_addr = 3'($urandom_range(7));
      if ($urandom_range(5) == 0) begin
        reg_we = 1'b1;
        reg_wdata = 16'($urandom);
      end
      step("rand");
      reg_we = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
